// File: rtl/capture_pkg.sv
// Shared types and constants for the capture/dump controller.
package capture_pkg;

  localparam int DEC_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    ARMED,
    POST,
    DONE,
    DUMP_RD,
    DUMP_WAIT
  } cap_state_t;

endpackage

// File: rtl/trig_detect.sv
// Per-channel trigger synchroniser and edge detector; emits a 1-clk pulse for the
// selected channel and polarity, 3 clk after the raw comparator changes.
module trig_detect #(
  parameter int NCH = 3,
  parameter int CSW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [NCH-1:0] trig,
  input  logic [CSW-1:0] trig_src,
  input  logic           trig_edge,
  output logic           edge_pulse
);

  logic [NCH-1:0] sync1, sync2, hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      hist  <= '0;
    end else begin
      sync1 <= trig;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  always_comb begin
    edge_pulse = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (trig_src == CSW'(i))
        edge_pulse = trig_edge ? (sync2[i] & ~hist[i]) : (~sync2[i] & hist[i]);
    end
  end

endmodule

// File: rtl/capture_dump_ctrl.sv
// Circular multi-channel capture with programmable trigger, decimation and auto-trigger,
// followed by an oldest-first single-channel byte dump to the UART response path.
module capture_dump_ctrl
  import capture_pkg::*;
#(
  parameter int NCH = 3,
  parameter int AW  = 9,
  parameter int CSW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             rclk,
  input  logic [NCH-1:0]   trig,
  input  logic [CSW-1:0]   trig_src,
  input  logic             trig_edge,
  input  logic             auto_trig,
  input  logic             force_trig,
  input  logic [AW-1:0]    trig_pos,
  input  logic [DEC_W-1:0] decimator,
  input  logic             arm,
  input  logic             clr_cap_done,
  output logic             cap_done,
  output logic [AW-1:0]    trig_addr,
  output logic             ram_en,
  output logic             ram_we,
  output logic [AW-1:0]    ram_addr,
  input  logic [8*NCH-1:0] ram_rdata,
  input  logic             dump_start,
  input  logic [CSW-1:0]   dump_ch,
  output logic [7:0]       dump_data,
  output logic             dump_vld,
  input  logic             dump_ack,
  output logic             dump_busy
);

  localparam int          DEPTH   = 2 ** AW;
  localparam int          DCNT_W  = 2 ** DEC_W - 1;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  cap_state_t        state;
  logic [AW-1:0]     wptr, raddr;
  logic [AW:0]       wcnt, bcnt, pre_len;
  logic [DCNT_W-1:0] dcnt, dec_mask;
  logic              pending, rphase, trig_pulse, wr_slot, step, trigger_now;
  logic [7:0]        sel_byte;

  trig_detect #(.NCH(NCH), .CSW(CSW)) u_trig (
    .clk        (clk),
    .rst_n      (rst_n),
    .trig       (trig),
    .trig_src   (trig_src),
    .trig_edge  (trig_edge),
    .edge_pulse (trig_pulse)
  );

  // Strobes are updated on the edge that starts a slot (rclk 1->0), so they are
  // stable through the slot and at the following rclk rise where the RAM samples.
  assign step     = rclk;
  assign dec_mask = DCNT_W'((32'd1 << decimator) - 32'd1);
  assign wr_slot  = (dcnt == '0);
  // trig_pos is AW bits wide, so it can never exceed DEPTH-1.
  assign pre_len  = DEPTH_C - {1'b0, trig_pos};
  assign trigger_now = pending | trig_pulse | force_trig | (auto_trig && wcnt == DEPTH_C);

  always_comb begin
    sel_byte = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (dump_ch == CSW'(i)) sel_byte = ram_rdata[i*8 +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rclk      <= 1'b0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      cap_done  <= 1'b0;
      trig_addr <= '0;
      dump_data <= '0;
      dump_vld  <= 1'b0;
      dump_busy <= 1'b0;
      wptr      <= '0;
      raddr     <= '0;
      wcnt      <= '0;
      bcnt      <= '0;
      dcnt      <= '0;
      pending   <= 1'b0;
      rphase    <= 1'b0;
    end else begin
      rclk     <= ~rclk;
      dump_vld <= 1'b0;
      if (arm) begin
        state     <= PRE;
        wptr      <= '0;
        wcnt      <= '0;
        dcnt      <= '0;
        cap_done  <= 1'b0;
        pending   <= 1'b0;
        dump_busy <= 1'b0;
        if (step) begin
          ram_en <= 1'b0;
          ram_we <= 1'b0;
        end
      end else begin
        if (clr_cap_done) cap_done <= 1'b0;
        if (state == ARMED && (trig_pulse || force_trig)) pending <= 1'b1;
        case (state)
          PRE, ARMED, POST: if (step) begin
            ram_en   <= wr_slot;
            ram_we   <= wr_slot;
            ram_addr <= wptr;
            dcnt     <= (dcnt >= dec_mask) ? '0 : dcnt + 1'b1;
            if (wr_slot) begin
              wptr <= wptr + 1'b1;
              if (state == PRE) begin
                if (wcnt + 1'b1 == pre_len) begin
                  state <= ARMED;
                  wcnt  <= '0;
                end else begin
                  wcnt <= wcnt + 1'b1;
                end
              end else if (state == ARMED) begin
                if (trigger_now) begin
                  trig_addr <= wptr;
                  pending   <= 1'b0;
                  wcnt      <= '0;
                  if (trig_pos == '0) begin
                    state    <= DONE;
                    cap_done <= 1'b1;
                  end else begin
                    state <= POST;
                  end
                end else if (wcnt != DEPTH_C) begin
                  wcnt <= wcnt + 1'b1;
                end
              end else begin
                if (wcnt + 1'b1 == {1'b0, trig_pos}) begin
                  state    <= DONE;
                  cap_done <= 1'b1;
                end else begin
                  wcnt <= wcnt + 1'b1;
                end
              end
            end
          end
          DONE: begin
            if (step) begin
              ram_en <= 1'b0;
              ram_we <= 1'b0;
            end
            if (dump_start) begin
              state     <= DUMP_RD;
              raddr     <= wptr;
              bcnt      <= '0;
              rphase    <= 1'b0;
              dump_busy <= 1'b1;
            end
          end
          DUMP_RD: if (step) begin
            if (!rphase) begin
              ram_en   <= 1'b1;
              ram_we   <= 1'b0;
              ram_addr <= raddr;
              rphase   <= 1'b1;
            end else begin
              ram_en    <= 1'b0;
              dump_data <= sel_byte;
              dump_vld  <= 1'b1;
              rphase    <= 1'b0;
              state     <= DUMP_WAIT;
            end
          end
          DUMP_WAIT: if (dump_ack) begin
            raddr <= raddr + 1'b1;
            bcnt  <= bcnt + 1'b1;
            if (bcnt + 1'b1 == DEPTH_C) begin
              state     <= DONE;
              dump_busy <= 1'b0;
            end else begin
              state <= DUMP_RD;
            end
          end
          default: if (step) begin
            ram_en <= 1'b0;
            ram_we <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_capture_dump_ctrl.sv
// Bench for capture_dump_ctrl: behavioural channel RAM, write log and a byte scoreboard for dumps.
module tb_capture_dump_ctrl;

  localparam int NCH = 3, AW = 4, CSW = 2, DEPTH = 16;

  logic clk = 1'b0, rst_n = 1'b0;
  logic rclk, cap_done, ram_en, ram_we, dump_vld, dump_busy;
  logic [AW-1:0] trig_addr, ram_addr;
  logic [7:0] dump_data;
  logic [NCH-1:0] trig = '0;
  logic [CSW-1:0] trig_src = '0, dump_ch = '0;
  logic trig_edge = 1'b1, auto_trig = 1'b0, force_trig = 1'b0, arm = 1'b0;
  logic clr_cap_done = 1'b0, dump_start = 1'b0, dump_ack = 1'b0;
  logic [AW-1:0] trig_pos = '0;
  logic [3:0] decimator = '0;
  logic [8*NCH-1:0] ram_rdata = '0;

  capture_dump_ctrl #(.NCH(NCH), .AW(AW), .CSW(CSW)) dut (
    .clk(clk), .rst_n(rst_n), .rclk(rclk), .trig(trig), .trig_src(trig_src),
    .trig_edge(trig_edge), .auto_trig(auto_trig), .force_trig(force_trig),
    .trig_pos(trig_pos), .decimator(decimator), .arm(arm), .clr_cap_done(clr_cap_done),
    .cap_done(cap_done), .trig_addr(trig_addr), .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_rdata(ram_rdata), .dump_start(dump_start), .dump_ch(dump_ch),
    .dump_data(dump_data), .dump_vld(dump_vld), .dump_ack(dump_ack), .dump_busy(dump_busy)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  logic [7:0] mem [NCH][DEPTH];
  logic [AW-1:0] waddr [$];
  time wtime [$];
  int unsigned wr_idx = 0, rd_cnt = 0;
  logic [7:0] exp_q [$];
  logic [8*NCH-1:0] rd_tmp;

  function automatic logic [7:0] pat(int unsigned i, int unsigned c);
    return 8'(i * 7 + c * 85 + 1);
  endfunction

  always @(posedge rclk) begin
    if (ram_en && ram_we) begin
      for (int c = 0; c < NCH; c++) mem[c][ram_addr] = pat(wr_idx, c);
      waddr.push_back(ram_addr);
      wtime.push_back($time);
      wr_idx++;
    end else if (ram_en) begin
      for (int c = 0; c < NCH; c++) rd_tmp[c*8 +: 8] = mem[c][ram_addr];
      ram_rdata <= rd_tmp;
      rd_cnt++;
    end
  end

  task automatic do_arm();
    @(negedge clk) arm = 1'b1;
    @(negedge clk) arm = 1'b0;
    waddr.delete(); wtime.delete(); wr_idx = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({rclk, ram_en, ram_we, ram_addr, cap_done, trig_addr, dump_data, dump_vld, dump_busy} !== '0) begin
      bad++; $display("FAIL reset_values got=%h want=0",
        {rclk, ram_en, ram_we, ram_addr, cap_done, trig_addr, dump_data, dump_vld, dump_busy});
    end
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    total++;
    if ({ram_en, cap_done, dump_busy, waddr.size() == 0} !== 4'b0001) begin
      bad++; $display("FAIL idle_quiet got=%b want=0001", {ram_en, cap_done, dump_busy, waddr.size() == 0});
    end
  endtask

  task automatic test_capture();
    time t_edge; int idx = -1, seq_err = 0, n;
    trig_pos = 4; decimator = 0; trig_src = 1; trig_edge = 1; auto_trig = 0; trig = '0;
    do_arm();
    repeat (39) @(negedge clk);
    trig[1] = 1'b1; t_edge = $time;
    for (int i = 0; i < 200 && !cap_done; i++) @(negedge clk);
    repeat (6) @(negedge clk);
    foreach (wtime[i]) if (idx < 0 && wtime[i] >= t_edge + 30) idx = i;
    foreach (waddr[i]) if (waddr[i] != AW'(i)) seq_err++;
    total++; if (cap_done !== 1'b1) begin bad++; $display("FAIL cap1_done got=%b want=1", cap_done); end
    total++; if (idx < 0 || trig_addr !== AW'(idx)) begin bad++; $display("FAIL cap1_trig_addr got=%0d want=%0d", trig_addr, idx); end
    total++; if (waddr.size() - idx - 1 !== 4) begin bad++; $display("FAIL cap1_post_writes got=%0d want=4", waddr.size() - idx - 1); end
    total++; if (seq_err !== 0) begin bad++; $display("FAIL cap1_addr_seq got=%0d bad addrs want=0", seq_err); end
    n = waddr.size();
    repeat (10) @(negedge clk);
    total++; if (waddr.size() !== n) begin bad++; $display("FAIL cap1_done_quiet got=%0d want=%0d", waddr.size(), n); end
  endtask

  task automatic test_pre_ignore();
    time t_edge; int idx = -1;
    trig = '0;
    repeat (6) @(negedge clk);
    do_arm();
    repeat (5) @(negedge clk);
    trig[1] = 1'b1;
    repeat (10) @(negedge clk);
    trig[1] = 1'b0;
    repeat (14) @(negedge clk);
    trig[1] = 1'b1; t_edge = $time;
    for (int i = 0; i < 200 && !cap_done; i++) @(negedge clk);
    repeat (6) @(negedge clk);
    foreach (wtime[i]) if (idx < 0 && wtime[i] >= t_edge + 30) idx = i;
    total++; if (cap_done !== 1'b1) begin bad++; $display("FAIL pre_done got=%b want=1", cap_done); end
    total++; if (idx < 0 || trig_addr !== AW'(idx)) begin bad++; $display("FAIL pre_trig_addr got=%0d want=%0d", trig_addr, idx); end
    total++; if (waddr.size() - idx - 1 !== 4) begin bad++; $display("FAIL pre_post_writes got=%0d want=4", waddr.size() - idx - 1); end
    trig = '0;
  endtask

  task automatic test_decimation_auto();
    int gap_err = 0, seq_err = 0;
    trig_src = 0; trig = '0; decimator = 2; auto_trig = 1; trig_pos = 4;
    do_arm();
    for (int i = 0; i < 800 && !cap_done; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    for (int i = 1; i < wtime.size(); i++) if (wtime[i] - wtime[i-1] != 80) gap_err++;
    foreach (waddr[i]) if (waddr[i] != AW'(i)) seq_err++;
    total++; if (cap_done !== 1'b1) begin bad++; $display("FAIL auto_done got=%b want=1", cap_done); end
    total++; if (waddr.size() !== 33) begin bad++; $display("FAIL auto_writes got=%0d want=33", waddr.size()); end
    total++; if (trig_addr !== AW'(12)) begin bad++; $display("FAIL auto_trig_addr got=%0d want=12", trig_addr); end
    total++; if (gap_err !== 0) begin bad++; $display("FAIL dec_spacing got=%0d bad gaps want=0", gap_err); end
    total++; if (seq_err !== 0) begin bad++; $display("FAIL auto_addr_seq got=%0d want=0", seq_err); end
    auto_trig = 0; decimator = 0;
  endtask

  task automatic test_dump();
    logic [7:0] e;
    dump_ch = 2;
    @(negedge clk) dump_start = 1'b1;
    for (int k = 0; k < DEPTH; k++) exp_q.push_back(pat(wr_idx - DEPTH + k, 2));
    @(negedge clk) dump_start = 1'b0;
    total++; if (dump_busy !== 1'b1) begin bad++; $display("FAIL dump_busy_set got=%b want=1", dump_busy); end
    for (int k = 0; k < DEPTH; k++) begin
      for (int i = 0; i < 20 && !dump_vld; i++) @(negedge clk);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
      total++;
      if (dump_vld !== 1'b1) begin bad++; $display("FAIL dump_vld_timeout byte=%0d got=0 want=1", k); end
      else if (dump_data !== e) begin bad++; $display("FAIL dump_byte%0d got=%h want=%h", k, dump_data, e); end
      repeat (10) @(negedge clk);
      dump_ack = 1'b1;
      @(negedge clk) dump_ack = 1'b0;
    end
    repeat (4) @(negedge clk);
    total++; if (dump_busy !== 1'b0) begin bad++; $display("FAIL dump_busy_drop got=%b want=0", dump_busy); end
    total++; if (cap_done !== 1'b1) begin bad++; $display("FAIL dump_cap_keep got=%b want=1", cap_done); end
  endtask

  task automatic test_abort();
    time t_f; int idx = -1, rc, n; logic [7:0] e;
    trig_pos = 4; trig_src = 1; trig = '0;
    do_arm();
    repeat (40) @(negedge clk);
    rc = rd_cnt;
    dump_start = 1'b1; @(negedge clk) dump_start = 1'b0;
    repeat (6) @(negedge clk);
    total++; if ({dump_busy, rd_cnt == rc} !== 2'b01) begin bad++; $display("FAIL dump_in_armed got=%b want=01", {dump_busy, rd_cnt == rc}); end
    force_trig = 1'b1; t_f = $time; @(negedge clk) force_trig = 1'b0;
    for (int i = 0; i < 200 && !cap_done; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    foreach (wtime[i]) if (idx < 0 && wtime[i] >= t_f + 10) idx = i;
    total++; if (idx < 0 || trig_addr !== AW'(idx)) begin bad++; $display("FAIL force_trig_addr got=%0d want=%0d", trig_addr, idx); end
    clr_cap_done = 1'b1; @(negedge clk) clr_cap_done = 1'b0;
    total++; if (cap_done !== 1'b0) begin bad++; $display("FAIL clr_cap_done got=%b want=0", cap_done); end
    dump_ch = 0;
    dump_start = 1'b1;
    for (int k = 0; k < DEPTH; k++) exp_q.push_back(pat(wr_idx - DEPTH + k, 0));
    @(negedge clk) dump_start = 1'b0;
    for (int i = 0; i < 20 && !dump_vld; i++) @(negedge clk);
    e = exp_q.pop_front();
    total++; if (dump_vld !== 1'b1 || dump_data !== e) begin bad++; $display("FAIL abort_first_byte got=%h vld=%b want=%h", dump_data, dump_vld, e); end
    exp_q.delete();
    repeat (3) @(negedge clk);
    do_arm();
    total++; if ({dump_busy, cap_done} !== 2'b00) begin bad++; $display("FAIL arm_in_dump got=%b want=00", {dump_busy, cap_done}); end
    repeat (10) @(negedge clk);
    total++; if ((waddr.size() > 0) !== 1'b1) begin bad++; $display("FAIL rearm_writes got=%0d want>0", waddr.size()); end
    repeat (30) @(negedge clk);
    force_trig = 1'b1; @(negedge clk) force_trig = 1'b0;
    repeat (4) @(negedge clk);
    total++; if (cap_done !== 1'b0) begin bad++; $display("FAIL post_not_done got=%b want=0", cap_done); end
    rst_n = 1'b0; #1;
    total++;
    if ({rclk, ram_en, ram_we, ram_addr, cap_done, trig_addr, dump_data, dump_vld, dump_busy} !== '0) begin
      bad++; $display("FAIL reset_in_post got=%h want=0",
        {rclk, ram_en, ram_we, ram_addr, cap_done, trig_addr, dump_data, dump_vld, dump_busy});
    end
    n = waddr.size();
    repeat (6) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    total++; if (waddr.size() !== n) begin bad++; $display("FAIL reset_no_write got=%0d want=%0d", waddr.size(), n); end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_pre_ignore();
    test_decimation_auto();
    test_dump();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
